// File: rtl/lvds_tx_packer.sv
// rtl/lvds_tx_packer.sv - RGB888 to 7:1 LVDS word packer with internal video timing generator
// Counters and FSM advance every pclk; dout is registered one cycle behind the counter position it describes.
module lvds_tx_packer #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 21,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        en,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        clr_underflow,
  output logic        underflow,
  output logic        sof,
  output logic        busy,
  output logic [48:0] dout
);

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Lane L slot k lands on bit k*7+L; each lane vector below is indexed by slot.
  function automatic logic [48:0] pack_word(input logic [23:0] px, input logic hs,
                                            input logic vs, input logic de);
    logic [6:0][6:0] lane;
    logic [7:0]      r;
    logic [7:0]      g;
    logic [7:0]      b;
    logic [48:0]     w;
    r = px[23:16];
    g = px[15:8];
    b = px[7:0];
    lane[0] = 7'b1100011;
    lane[1] = {g[0], r[5:0]};
    lane[2] = {b[1:0], g[5:1]};
    lane[3] = {de, vs, hs, b[5:2]};
    lane[4] = {1'b0, b[7:6], g[7:6], r[7:6]};
    lane[5] = 7'd0;
    lane[6] = 7'd0;
    w = '0;
    for (int k = 0; k < 7; k++) begin
      for (int l = 0; l < 7; l++) begin
        w[k*7+l] = lane[l][k];
      end
    end
    return w;
  endfunction

  localparam logic [48:0] IDLE_WORD = pack_word(24'd0, !HS_POL, !VS_POL, 1'b0);

  state_t      state_q, state_d;
  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;
  logic        underflow_q, underflow_d;
  logic        sof_q, sof_d;
  logic [48:0] dout_q, dout_d;

  logic        active;
  logic        at_end;
  logic        de;
  logic        hs;
  logic        vs;
  logic        starve;
  logic [23:0] px;
  logic [11:0] h_adv;
  logic [11:0] v_adv;

  always_comb begin
    active = (state_q != ST_IDLE);
    at_end = (h_q == H_LAST) && (v_q == V_LAST);
    de     = active && (h_q < H_ACT) && (v_q < V_ACT);
    hs     = (active && (h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : !HS_POL;
    vs     = (active && (v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : !VS_POL;
    starve = de && !pix_valid;
    // Starved active pixels go out as black so the link keeps its DE cadence.
    px     = (de && pix_valid) ? pix_data : 24'd0;
  end

  assign pix_ready = de;

  always_comb begin
    h_adv = h_q + 12'd1;
    v_adv = v_q;
    if (h_q == H_LAST) begin
      h_adv = 12'd0;
      v_adv = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_adv;
    v_d     = v_adv;
    case (state_q)
      ST_IDLE: begin
        h_d = 12'd0;
        v_d = 12'd0;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) state_d = at_end ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (en)          state_d = ST_RUN;
        else if (at_end) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        h_d     = 12'd0;
        v_d     = 12'd0;
      end
    endcase
  end

  always_comb begin
    dout_d      = pack_word(px, hs, vs, de);
    sof_d       = active && (h_q == 12'd0) && (v_q == 12'd0);
    // A new starvation outranks a simultaneous clear.
    underflow_d = starve || (underflow_q && !clr_underflow);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      h_q         <= 12'd0;
      v_q         <= 12'd0;
      underflow_q <= 1'b0;
      sof_q       <= 1'b0;
      dout_q      <= IDLE_WORD;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      underflow_q <= underflow_d;
      sof_q       <= sof_d;
      dout_q      <= dout_d;
    end
  end

  assign underflow = underflow_q;
  assign sof       = sof_q;
  assign busy      = (state_q != ST_IDLE);
  assign dout      = dout_q;

endmodule

// File: tb/tb_lvds_tx_packer.sv
// tb/tb_lvds_tx_packer.sv - scoreboard bench for lvds_tx_packer on an 8x5 total raster
module tb_lvds_tx_packer;

  localparam int HA = 4, HFP = 1, HSY = 2, HBP = 1;
  localparam int VA = 2, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam bit HPOL = 1'b1;
  localparam bit VPOL = 1'b1;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [23:0] pix_data = 24'd0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        clr_underflow = 1'b0;
  logic        underflow;
  logic        sof;
  logic        busy;
  logic [48:0] dout;

  always #5 pclk = ~pclk;

  lvds_tx_packer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HPOL), .VS_POL(VPOL)
  ) dut (
    .pclk(pclk), .reset(reset), .en(en), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .clr_underflow(clr_underflow),
    .underflow(underflow), .sof(sof), .busy(busy), .dout(dout)
  );

  typedef struct {
    logic [48:0] dout;
    logic        sof;
    logic        uf;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  logic rdy_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference: "active" flag plus a linear position inside the frame.
  bit   m_active = 1'b0;
  int   m_pos = 0;
  bit   m_uf = 1'b0;

  // Each lane is written in transmit order, slot 0 leftmost.
  function automatic logic [48:0] exp_word(input logic [23:0] px, input bit hs,
                                           input bit vs, input bit de);
    bit [0:6][0:6] lanes;
    logic [7:0] r, g, b;
    logic [48:0] w;
    r = px[23:16];
    g = px[15:8];
    b = px[7:0];
    lanes[0] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    lanes[1] = {r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
    lanes[2] = {g[1], g[2], g[3], g[4], g[5], b[0], b[1]};
    lanes[3] = {b[2], b[3], b[4], b[5], hs, vs, de};
    lanes[4] = {r[6], r[7], g[6], g[7], b[6], b[7], 1'b0};
    lanes[5] = '0;
    lanes[6] = '0;
    w = '0;
    for (int l = 0; l < 7; l++)
      for (int k = 0; k < 7; k++)
        w[k*7+l] = lanes[l][k];
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit e, input bit pv, input logic [23:0] pd,
                      input bit clr, input bit rst);
    exp_t x;
    int h, v;
    bit de, hs, vs, sf, last;
    logic [23:0] px;
    @(negedge pclk);
    en = e;
    pix_valid = pv;
    pix_data = pd;
    clr_underflow = clr;
    reset = rst;
    #1;
    if (rst) begin
      chk("rst_dout", 64'(dout), 64'(exp_word(24'd0, !HPOL, !VPOL, 1'b0)));
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_sof", 64'(sof), 64'd0);
      chk("rst_underflow", 64'(underflow), 64'd0);
      m_active = 1'b0;
      m_pos = 0;
      m_uf = 1'b0;
      x.dout = exp_word(24'd0, !HPOL, !VPOL, 1'b0);
      x.sof = 1'b0;
      x.uf = 1'b0;
      x.busy = 1'b0;
      exp_q.push_back(x);
      rdy_q.push_back(1'b0);
    end else begin
      h = m_pos % HT;
      v = m_pos / HT;
      de = m_active && h < HA && v < VA;
      hs = (m_active && h >= HA + HFP && h < HA + HFP + HSY) ? HPOL : !HPOL;
      vs = (m_active && v >= VA + VFP && v < VA + VFP + VSY) ? VPOL : !VPOL;
      px = (de && pv) ? pd : 24'd0;
      m_uf = (de && !pv) || (m_uf && !clr);
      sf = m_active && m_pos == 0;
      if (m_active) begin
        last = (m_pos == HT * VT - 1);
        m_pos = (m_pos + 1) % (HT * VT);
        if (!e && last) m_active = 1'b0;
      end else if (e) begin
        m_active = 1'b1;
      end
      x.dout = exp_word(px, hs, vs, de);
      x.sof = sf;
      x.uf = m_uf;
      x.busy = m_active;
      exp_q.push_back(x);
      rdy_q.push_back(de);
    end
  endtask

  initial begin : reg_monitor
    exp_t x;
    forever begin
      @(posedge pclk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("dout", 64'(dout), 64'(x.dout));
        chk("sof", 64'(sof), 64'(x.sof));
        chk("underflow", 64'(underflow), 64'(x.uf));
        chk("busy", 64'(busy), 64'(x.busy));
      end
    end
  end

  initial begin : ready_monitor
    logic r;
    forever begin
      @(negedge pclk);
      #3;
      if (rdy_q.size() > 0) begin
        r = rdy_q.pop_front();
        chk("pix_ready", 64'(pix_ready), 64'(r));
      end
    end
  end

  initial begin : stimulus
    int guard;
    bit e;
    repeat (3) step(1'b0, 1'b0, 24'd0, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'($urandom), 24'($urandom), 1'b0, 1'b0);

    repeat (45) step(1'b1, 1'b1, 24'hFF0000, 1'b0, 1'b0);

    // Starve at line 0, h=2 with a coincident clear on two consecutive frames.
    repeat (2 * HT * VT) begin
      if (m_active && m_pos == 2)
        step(1'b1, 1'b0, 24'($urandom), 1'b1, 1'b0);
      else
        step(1'b1, 1'($urandom_range(0, 7) != 0), 24'($urandom),
             1'($urandom_range(0, 3) == 0), 1'b0);
    end

    guard = 0;
    while (!(m_active && m_pos == HT + 3) && guard < 100) begin
      step(1'b1, 1'b1, 24'($urandom), 1'b0, 1'b0);
      guard++;
    end
    chk("reach_v1h3", 64'(guard < 100), 64'd1);
    repeat (HT * VT + 5) step(1'b0, 1'($urandom), 24'($urandom), 1'b0, 1'b0);

    guard = 0;
    step(1'b1, 1'b1, 24'($urandom), 1'b0, 1'b0);
    while (!(m_active && m_pos == 2) && guard < 100) begin
      step(1'b1, 1'b1, 24'($urandom), 1'b0, 1'b0);
      guard++;
    end
    chk("reach_v0h2", 64'(guard < 100), 64'd1);
    step(1'b1, 1'b1, 24'($urandom), 1'b0, 1'b1);
    repeat (HT * VT + 3) step(1'b1, 1'b1, 24'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    e = 1'b1;
    repeat (400) begin
      if ($urandom_range(0, 19) == 0) e = !e;
      step(e, 1'($urandom_range(0, 5) != 0), 24'($urandom),
           1'($urandom_range(0, 4) == 0), 1'b0);
    end
    repeat (HT * VT + 2) step(1'b0, 1'b1, 24'($urandom), 1'b1, 1'b0);

    guard = 0;
    while ((exp_q.size() > 0 || rdy_q.size() > 0) && guard < 10) begin
      @(posedge pclk);
      guard++;
    end
    #4;
    chk("queues_drained", 64'(exp_q.size() + rdy_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lvds_tx_packer.md
LVDS_TX_PACKER -- requirements
Module: lvds_tx_packer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports named pclk and reset.
REQ-002 Parameters SHALL be as follows (name, default, meaning):
- H_ACTIVE, 800, active pixels per line.
- H_FP, 40, horizontal front porch.
- H_SYNC, 128, horizontal sync width.
- H_BP, 88, horizontal back porch.
- V_ACTIVE, 480, active lines.
- V_FP, 1, vertical front porch.
- V_SYNC, 3, vertical sync width.
- V_BP, 21, vertical back porch.
- HS_POL, 1, HS active level.
- VS_POL, 1, VS active level.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- pclk, in, 1, pixel clock.
- reset, in, 1, asynchronous active-high reset.
- en, in, 1, run request.
- pix_data, in, 24, RGB888 {R[23:16],G[15:8],B[7:0]}.
- pix_valid, in, 1, source holds a pixel.
- pix_ready, out, 1, packer takes a pixel this cycle.
- clr_underflow, in, 1, clears the underflow flag.
- underflow, out, 1, sticky starvation flag.
- sof, out, 1, start-of-frame pulse.
- busy, out, 1, state is not IDLE.
- dout, out, 49, 7:1 serializer word.

Function
REQ-004 dout[k*7+L] SHALL carry slot k of lane L, where k=0..6, slot 0 is transmitted first, and L=0..6.
REQ-005 Lane 0 (clock lane) SHALL carry slots 0..6 = 1,1,0,0,0,1,1 on every cycle, including IDLE.
REQ-006 Lane 1 SHALL carry slots 0..6 = R0,R1,R2,R3,R4,R5,G0.
REQ-007 Lane 2 SHALL carry slots 0..6 = G1,G2,G3,G4,G5,B0,B1.
REQ-008 Lane 3 SHALL carry slots 0..6 = B2,B3,B4,B5,HS,VS,DE.
REQ-009 Lane 4 SHALL carry slots 0..6 = R6,R7,G6,G7,B6,B7,0.
REQ-010 Lanes 5 and 6 SHALL be constant 0.
REQ-011 The horizontal counter h SHALL run 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP. The vertical counter v SHALL run 0..V_TOTAL-1 and increment when h wraps. Both counters SHALL be 12 bits.
REQ-012 Timing signals SHALL be derived from the counters:
- DE = (h<H_ACTIVE && v<V_ACTIVE).
- HS = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else !HS_POL.
- VS SHALL be defined the same way from v and the V_* parameters.
REQ-013 The state machine SHALL have three states: IDLE, RUN, DRAIN.
- IDLE->RUN when en=1. The counters SHALL be at h=0,v=0 in the first RUN cycle.
- RUN->DRAIN when en=0.
- DRAIN->RUN when en=1, with counting uninterrupted.
- RUN or DRAIN -> IDLE on the cycle h=H_TOTAL-1, v=V_TOTAL-1, if en=0.
REQ-014 In IDLE:
- Counters SHALL hold at 0.
- pix_ready SHALL be 0.
- Lanes 1-4 SHALL carry zero pixel data, HS=!HS_POL, VS=!VS_POL, DE=0.
REQ-015 pix_ready SHALL be combinational and equal to (state!=IDLE && DE at the current h,v). A pixel is accepted when pix_valid && pix_ready.
REQ-016 dout SHALL be registered with a latency of one cycle: data accepted at cycle t, and the HS/VS/DE of the counters at t, SHALL appear on dout at t+1.
REQ-017 When pix_ready=1 and pix_valid=0, dout SHALL carry pixel 0x000000 with DE=1, and underflow SHALL set.
REQ-018 underflow SHALL stay set until clr_underflow. If a set and a clear occur in the same cycle, the set SHALL win.
REQ-019 sof SHALL be a 1-cycle pulse, registered and aligned with the dout word of h=0, v=0 in a non-IDLE state.
REQ-020 pix_data SHALL be ignored whenever pix_ready=0.

Reset
REQ-021 While reset=1, asynchronously:
- State SHALL be IDLE, with h=0 and v=0.
- underflow=0, sof=0, busy=0, pix_ready=0.
- dout SHALL equal the IDLE word.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately. After release, the next frame SHALL start only at h=0, v=0 via en.

Verification
Scenarios use H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=5); HS_POL=VS_POL=1.
REQ-023 Reset release with en=0 -> dout lane0 slots = 1100011 every cycle; every other lane bit 0 except HS/VS = 0; pix_ready=0; busy=0.
REQ-024 en=1, pix_valid=1, pix_data=0xFF0000 -> pix_ready high for 4 of every 8 cycles on lines 0-1, then low for lines 2-4. The first dout word SHALL have sof=1, lane1 slots 0-5 = 1, and lane4 slots 0-1 = 1.
REQ-025 Counter positions -> HS=1 exactly at h=5,6; VS=1 exactly at v=3; both delayed one cycle on dout.
REQ-026 pix_valid=0 during h=2 of line 0 -> that output word carries DE=1 and zero RGB; underflow=1 from the next cycle. clr_underflow=1 coincident with a new starvation -> underflow stays 1.
REQ-027 en dropped at v=1, h=3 -> frame completes through v=4, h=7; IDLE (busy=0) on the next cycle; no second sof.
REQ-028 reset pulsed at v=0, h=2 -> dout is the IDLE word immediately; after release with en=1, the next sof appears one cycle after the first RUN cycle.
